// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush squash, hold and writeback patch
module id_ex_stage #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [4:0]        id_rd,
   input  logic [XLEN-1:0]   id_rdata1,
   input  logic [XLEN-1:0]   id_rdata2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_mem_read,
   input  logic              id_reg_write,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [XLEN-1:0]   ex_rdata1,
   output logic [XLEN-1:0]   ex_rdata2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_mem_read,
   output logic              ex_reg_write,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt
);
   logic load_use, ld, take, patch, bubble;
   assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
   assign stall_o  = (load_use | hold_i) & ~flush_i;
   assign ld       = flush_i | (~hold_i & ~load_use);
   assign take     = ~flush_i & ~hold_i & ~load_use & id_valid;
   assign patch    = wb_reg_write & (wb_rd != 5'd0);
   assign bubble   = load_use & ~hold_i & ~flush_i;
   // Datapath fields: load from ID on flush or normal advance, patch from writeback while holding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_pc     <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_rdata1 <= '0;
         ex_rdata2 <= '0;
         ex_imm    <= '0;
      end else if (ld) begin
         ex_pc     <= id_pc;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_rdata1 <= id_rdata1;
         ex_rdata2 <= id_rdata2;
         ex_imm    <= id_imm;
      end else if (hold_i) begin
         if (patch && wb_rd == ex_rs1) ex_rdata1 <= wb_data;
         if (patch && wb_rd == ex_rs2) ex_rdata2 <= wb_data;
      end
   end
   // Control fields: cleared by flush, bubble or invalid ID; frozen while holding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_ctrl      <= '0;
      end else if (flush_i || !hold_i) begin
         ex_valid     <= take;
         ex_mem_read  <= take & id_mem_read;
         ex_reg_write <= take & id_reg_write;
         ex_ctrl      <= take ? id_ctrl : '0;
      end
   end
   // Saturating count of inserted load-use bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bubble_cnt <= '0;
      else if (bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed check of id_ex_stage plus reset and saturation sequences
module tb_id_ex_stage;
   localparam int XLEN = 64, CTRL_W = 8, CNT_W = 4, NV = 17;
   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_mem_read = 0, id_reg_write = 0;
   logic flush_i = 0, hold_i = 0, wb_reg_write = 0;
   logic [XLEN-1:0] id_pc = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0, wb_data = '0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
   logic [CTRL_W-1:0] id_ctrl = '0;
   logic ex_valid, ex_mem_read, ex_reg_write, stall_o;
   logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0] bubble_cnt;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd;
      logic [63:0] d1, d2; logic [7:0] ctrl; logic mr, fl, hd, we; logic [4:0] wrd; logic [63:0] wd;
      logic s, ev; logic [4:0] ers1, ers2, erd; logic [63:0] ed1, ed2; logic emr; logic [7:0] ectrl;
      logic [63:0] epc; logic [3:0] ecnt;
   } vec_t;
   vec_t tbl[NV];

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rdata1(id_rdata1),
      .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
      .id_reg_write(id_reg_write), .flush_i(flush_i), .hold_i(hold_i), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .stall_o(stall_o),
      .bubble_cnt(bubble_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ex_valid"}, 64'(ex_valid), 0);
      chk({tag, " ex_pc"}, ex_pc, 0);
      chk({tag, " ex_rs1"}, 64'(ex_rs1), 0);
      chk({tag, " ex_rs2"}, 64'(ex_rs2), 0);
      chk({tag, " ex_rd"}, 64'(ex_rd), 0);
      chk({tag, " ex_rdata1"}, ex_rdata1, 0);
      chk({tag, " ex_rdata2"}, ex_rdata2, 0);
      chk({tag, " ex_imm"}, ex_imm, 0);
      chk({tag, " ex_ctrl"}, 64'(ex_ctrl), 0);
      chk({tag, " ex_mem_read"}, 64'(ex_mem_read), 0);
      chk({tag, " ex_reg_write"}, 64'(ex_reg_write), 0);
      chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 0);
   endtask

   task automatic apply(input vec_t t, input int i);
      id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
      id_rd = t.rd; id_rdata1 = t.d1; id_rdata2 = t.d2; id_ctrl = t.ctrl; id_mem_read = t.mr;
      id_reg_write = 1'b1; id_pc = 64'h100 + 64'(4 * i); id_imm = 64'(i);
      flush_i = t.fl; hold_i = t.hd; wb_reg_write = t.we; wb_rd = t.wrd; wb_data = t.wd;
   endtask

   initial begin
      //         v rs1 rs2 u1 u2 rd  d1       d2       ctrl  mr fl hd we wrd wd          s ev ers1 ers2 erd ed1      ed2       emr ectrl epc     ecnt
      tbl[0]  = '{1, 1,  2,  1, 1, 3,  'h11,    'h22,    'h21, 0, 0, 0, 0, 0,  0,          0, 1, 1,  2,  3,  'h11,    'h22,     0, 'h21, 'h100, 0};
      tbl[1]  = '{1, 2,  0,  1, 0, 5,  'h1000,  0,       'h42, 1, 0, 0, 0, 0,  0,          0, 1, 2,  0,  5,  'h1000,  0,        1, 'h42, 'h104, 0};
      tbl[2]  = '{1, 5,  6,  1, 1, 7,  'hAA,    'hBB,    'h21, 0, 0, 0, 0, 0,  0,          1, 0, 2,  0,  5,  'h1000,  0,        0, 0,    'h104, 1};
      tbl[3]  = '{1, 5,  6,  1, 1, 7,  'hAA,    'hBB,    'h21, 0, 0, 0, 0, 0,  0,          0, 1, 5,  6,  7,  'hAA,    'hBB,     0, 'h21, 'h10c, 1};
      tbl[4]  = '{1, 1,  0,  1, 0, 0,  5,       0,       'h42, 1, 0, 0, 0, 0,  0,          0, 1, 1,  0,  0,  5,       0,        1, 'h42, 'h110, 1};
      tbl[5]  = '{1, 0,  0,  1, 1, 8,  0,       0,       'h21, 0, 0, 0, 0, 0,  0,          0, 1, 0,  0,  8,  0,       0,        0, 'h21, 'h114, 1};
      tbl[6]  = '{1, 1,  7,  1, 0, 9,  'h30,    'h10,    'h42, 1, 0, 0, 0, 0,  0,          0, 1, 1,  7,  9,  'h30,    'h10,     1, 'h42, 'h118, 1};
      tbl[7]  = '{1, 9,  3,  1, 1, 10, 'h77,    'h88,    'h21, 0, 0, 1, 1, 7,  'hDEAD,     1, 1, 1,  7,  9,  'h30,    'hDEAD,   1, 'h42, 'h118, 1};
      tbl[8]  = '{1, 9,  3,  1, 1, 10, 'h77,    'h88,    'h21, 0, 0, 0, 0, 0,  0,          1, 0, 1,  7,  9,  'h30,    'hDEAD,   0, 0,    'h118, 2};
      tbl[9]  = '{1, 9,  3,  1, 1, 10, 'h77,    'h88,    'h21, 0, 0, 0, 0, 0,  0,          0, 1, 9,  3,  10, 'h77,    'h88,     0, 'h21, 'h124, 2};
      tbl[10] = '{1, 2,  0,  1, 0, 11, 'h40,    0,       'h42, 1, 0, 0, 0, 0,  0,          0, 1, 2,  0,  11, 'h40,    0,        1, 'h42, 'h128, 2};
      tbl[11] = '{1, 11, 4,  1, 1, 12, 'h55,    'h66,    'h21, 0, 1, 0, 0, 0,  0,          0, 0, 11, 4,  12, 'h55,    'h66,     0, 0,    'h12c, 2};
      tbl[12] = '{0, 0,  0,  1, 1, 13, 'h99,    'h9A,    'h21, 1, 0, 0, 0, 0,  0,          0, 0, 0,  0,  13, 'h99,    'h9A,     0, 0,    'h130, 2};
      tbl[13] = '{1, 4,  4,  1, 1, 16, 1,       2,       'h21, 0, 0, 1, 1, 0,  'hBEEF,     1, 0, 0,  0,  13, 'h99,    'h9A,     0, 0,    'h130, 2};
      tbl[14] = '{1, 6,  6,  1, 1, 14, 1,       2,       'h21, 0, 0, 0, 0, 0,  0,          0, 1, 6,  6,  14, 1,       2,        0, 'h21, 'h138, 2};
      tbl[15] = '{1, 4,  4,  1, 1, 16, 1,       2,       'h21, 0, 0, 1, 1, 6,  'hCAFE,     1, 1, 6,  6,  14, 'hCAFE,  'hCAFE,   0, 'h21, 'h138, 2};
      tbl[16] = '{1, 1,  2,  1, 1, 15, 3,       4,       'h21, 0, 1, 1, 1, 1,  'hF00,      0, 0, 1,  2,  15, 3,       4,        0, 0,    'h140, 2};

      #12;
      chk_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i], i);
         #3 chk($sformatf("r%0d stall_o", i), 64'(stall_o), 64'(tbl[i].s));
         @(posedge clk) #1;
         chk($sformatf("r%0d ex_valid", i), 64'(ex_valid), 64'(tbl[i].ev));
         chk($sformatf("r%0d ex_rs1", i), 64'(ex_rs1), 64'(tbl[i].ers1));
         chk($sformatf("r%0d ex_rs2", i), 64'(ex_rs2), 64'(tbl[i].ers2));
         chk($sformatf("r%0d ex_rd", i), 64'(ex_rd), 64'(tbl[i].erd));
         chk($sformatf("r%0d ex_rdata1", i), ex_rdata1, tbl[i].ed1);
         chk($sformatf("r%0d ex_rdata2", i), ex_rdata2, tbl[i].ed2);
         chk($sformatf("r%0d ex_mem_read", i), 64'(ex_mem_read), 64'(tbl[i].emr));
         chk($sformatf("r%0d ex_reg_write", i), 64'(ex_reg_write), 64'(tbl[i].ev));
         chk($sformatf("r%0d ex_ctrl", i), 64'(ex_ctrl), 64'(tbl[i].ectrl));
         chk($sformatf("r%0d ex_pc", i), ex_pc, tbl[i].epc);
         chk($sformatf("r%0d ex_imm", i), ex_imm, (tbl[i].epc - 64'h100) >> 2);
         chk($sformatf("r%0d bubble_cnt", i), 64'(bubble_cnt), 64'(tbl[i].ecnt));
      end

      apply(tbl[0], 0);
      @(posedge clk) #1;
      chk("pre-async ex_valid", 64'(ex_valid), 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async reset");
      chk("async reset stall_o", 64'(stall_o), 0);
      @(negedge clk) rst_n = 1'b1;

      apply('{1, 5, 0, 1, 0, 5, 0, 0, 'h42, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0);
      for (int e = 1; e <= 38; e++) begin
         @(posedge clk) #1;
         if (e == 16) chk("sat count 8", 64'(bubble_cnt), 8);
         if (e == 30) chk("sat count 15", 64'(bubble_cnt), 15);
      end
      chk("sat hold at max", 64'(bubble_cnt), 64'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with load-use hazard detection for the 64-bit RISC pipeline. It sits directly downstream of the register file and decoder. It captures the two read operands, immediate, PC and decoded control for the EX stage. It inserts one bubble on a load-use hazard, squashes on branch flush, and holds on downstream stall. While holding, it keeps its captured operands coherent with writeback.

Parameters:
XLEN, 64, datapath width of operands, immediate and PC
CTRL_W, 8, width of the opaque ALU/branch control bundle passed to EX
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a valid instruction
id_pc  input  XLEN  PC of the ID instruction
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_rd  input  5  destination register index
id_rdata1  input  XLEN  register file ReadData1
id_rdata2  input  XLEN  register file ReadData2
id_imm  input  XLEN  sign-extended immediate
id_ctrl  input  CTRL_W  decoded control bundle
id_mem_read  input  1  instruction is a load
id_reg_write  input  1  instruction writes rd
flush_i  input  1  branch/jump resolved taken in EX; squash ID
hold_i  input  1  downstream (MEM) stall; freeze this stage
wb_reg_write  input  1  writeback enable (same signal as register file write enable)
wb_rd  input  5  writeback register index
wb_data  input  XLEN  writeback data
ex_valid  output  1  EX stage holds a valid instruction
ex_pc  output  XLEN  registered PC
ex_rs1  output  5  registered rs1
ex_rs2  output  5  registered rs2
ex_rd  output  5  registered rd
ex_rdata1  output  XLEN  registered operand 1
ex_rdata2  output  XLEN  registered operand 2
ex_imm  output  XLEN  registered immediate
ex_ctrl  output  CTRL_W  registered control
ex_mem_read  output  1  registered load flag
ex_reg_write  output  1  registered write flag
stall_o  output  1  freeze PC and IF/ID (combinational)
bubble_cnt  output  CNT_W  count of inserted load-use bubbles

Behaviour:
- Reset: one clock; asynchronous active-low reset (rst_n). All outputs and registers go to 0 immediately on rst_n low, regardless of clk. Reset mid-operation discards the in-flight instruction.
- Hazard: load_use = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_o = (load_use | hold_i) & ~flush_i. This is purely combinational, with no cycle of latency.
- Per-edge update priority, highest first:
  - flush: ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0, ex_ctrl<=0. Other fields are don't-care and are loaded from ID.
  - hold_i: all fields retain their values except for the writeback patch below.
  - load_use: insert a bubble. ex_valid, ex_mem_read, ex_reg_write and ex_ctrl go to 0. The ID instruction is retained upstream by stall_o, so it re-presents next cycle, when load_use is 0.
  - otherwise: load all id_* fields; ex_valid<=id_valid.
- An invalid ID (id_valid=0) loads with ex_mem_read, ex_reg_write and ex_ctrl forced to 0.
- Hold writeback patch: if hold_i & ~flush_i & wb_reg_write & wb_rd!=0, then:
  - wb_rd==ex_rs1 sets ex_rdata1<=wb_data;
  - wb_rd==ex_rs2 sets ex_rdata2<=wb_data;
  - both apply when ex_rs1==ex_rs2.
- Normal-load writeback bypass is provided by the register file; this stage does not re-forward on load.
- bubble_cnt increments by 1 on each edge where a load-use bubble is inserted. It saturates at all-ones and never wraps.
- Register x0: ex_rd==0 never triggers a hazard. wb_rd==0 never patches.
- flush and load_use together: the flush wins, with no stall and no count increment.
- hold and load_use together: the stage holds with no count increment. The hazard is re-evaluated after the hold releases.

Test Plan:
- Reset sequence: drive rst_n=0 asynchronously mid-cycle with ex_valid=1 -> all outputs 0 before the next clk edge; bubble_cnt=0.
- Load-use hazard: a load with rd=5 is in EX; ID has an add with rs1=5 and use_rs1=1 -> stall_o=1 that cycle. The next edge gives ex_valid=0 and bubble_cnt=1. The following edge loads the add with ex_rs1=5.
- x0 load: EX holds a load with rd=0; ID reads rs1=0 -> stall_o=0 and no bubble.
- Flush priority: load_use=1 and flush_i=1 together -> stall_o=0; after the edge ex_valid=0 and bubble_cnt unchanged.
- Hold with writeback: ex_rs2=7 and ex_rdata2=0x10; hold_i=1, wb_reg_write=1, wb_rd=7, wb_data=0xDEAD -> after the edge ex_rdata2=0xDEAD and all other fields unchanged.
- Saturation: force 2^CNT_W+3 bubbles -> bubble_cnt holds at 0xFFFF for CNT_W=16.
